// File: rtl/addsub_pipe.sv
// Two-stage pipelined adder/subtractor with valid/ready handshakes.
// Optional signed saturation when ADDSUB_PIPE_SAT_EN is defined.
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int HI_W = WIDTH - LO_W;

    typedef struct packed {
        logic [LO_W-1:0] lo_sum;
        logic            lo_c;
        logic [HI_W-1:0] a_hi;
        logic [HI_W-1:0] b_hi;
        logic            sub;
    } s1_t;

    s1_t             s1_q;
    s1_t             s1_d;
    logic            s1_valid;
    logic            s2_valid;
    logic            s2_adv;
    logic            s1_load;
    logic            s2_load;

    logic [WIDTH-1:0] b_eff;
    logic [LO_W:0]    lo_full;

    logic [HI_W-1:0]  b_hi_eff;
    logic [HI_W:0]    hi_full;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_fin;
    logic             cout_d;
    logic             ovf_d;
    logic             a_sign;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_valid && s2_adv;
    assign out_valid = s2_valid;

    // Stage 1: low half of the carry chain.
    assign b_eff   = b ^ {WIDTH{sub}};
    assign lo_full = {1'b0, a[LO_W-1:0]}
                   + {1'b0, b_eff[LO_W-1:0]}
                   + {{LO_W{1'b0}}, sub};

    always_comb begin
        s1_d        = '0;
        s1_d.lo_sum = lo_full[LO_W-1:0];
        s1_d.lo_c   = lo_full[LO_W];
        s1_d.a_hi   = a[WIDTH-1:LO_W];
        s1_d.b_hi   = b[WIDTH-1:LO_W];
        s1_d.sub    = sub;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage 2: upper chain, flags and optional clamp.
    assign b_hi_eff = s1_q.b_hi ^ {HI_W{s1_q.sub}};
    assign hi_full  = {1'b0, s1_q.a_hi}
                    + {1'b0, b_hi_eff}
                    + {{HI_W{1'b0}}, s1_q.lo_c};
    assign sum_raw  = {hi_full[HI_W-1:0], s1_q.lo_sum};
    assign cout_d   = hi_full[HI_W];
    assign a_sign   = s1_q.a_hi[HI_W-1];
    assign ovf_d    = (a_sign == b_hi_eff[HI_W-1])
                   && (sum_raw[WIDTH-1] != a_sign);

`ifdef ADDSUB_PIPE_SAT_EN
    always_comb begin
        sum_fin = sum_raw;
        if (ovf_d) begin
            sum_fin = a_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_fin = sum_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                out  <= {cout_d, sum_fin};
                ovf  <= ovf_d;
                zero <= (sum_fin == '0);
                neg  <= sum_raw[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=8, LO_W=4).
// Arithmetic reference model plus directed and random handshake traffic.
module tb_addsub_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   out;
    logic         ovf;
    logic         zero;
    logic         neg;

    addsub_pipe #(.WIDTH(W), .LO_W(W/2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .ovf(ovf),
        .zero(zero),
        .neg(neg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sent = 0;
    bit lat_chk = 1'b0;
    bit prev_stall = 1'b0;
    logic [W+3:0] held = '0;
    logic [W+3:0] exp_q[$];
    int acc_q[$];
    logic [W-1:0] ta[32];
    logic [W-1:0] tb_v[32];
    logic         ts[32];

    // Result as {cout, sum, ovf, zero, neg} from plain integer arithmetic.
    function automatic logic [W+3:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic s);
        int ux, uy, sx, sy, ru, rs;
        logic signed [W-1:0] xs, ys;
        logic [W-1:0] sm;
        logic co, ov, zr, ng;
        ux = x;
        uy = y;
        xs = x;
        ys = y;
        sx = xs;
        sy = ys;
        ru = s ? ux - uy : ux + uy;
        rs = s ? sx - sy : sx + sy;
        co = s ? (ux >= uy) : (ru >= 2**W);
        ov = (rs > 2**(W-1) - 1) || (rs < -(2**(W-1)));
        sm = ru[W-1:0];
        ng = sm[W-1];
`ifdef ADDSUB_PIPE_SAT_EN
        if (ov) sm = x[W-1] ? 8'h80 : 8'h7F;
`endif
        zr = (sm == 0);
        return {co, sm, ov, zr, ng};
    endfunction

    task automatic cycle();
        logic [W+3:0] got, e;
        int t;
        @(negedge clk);
        cyc++;
        got = {out, ovf, zero, neg};
        if (prev_stall && out_valid) begin
            total++;
            assert (got === held) else begin
                bad++;
                $error("FAIL hold got=%h expected=%h", got, held);
            end
        end
        if (out_valid && out_ready) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL stray got=%h expected=none", got);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                total++;
                assert (got === e) else begin
                    bad++;
                    $error("FAIL result got=%h expected=%h", got, e);
                end
                if (lat_chk) begin
                    total++;
                    assert (cyc - t === 2) else begin
                        bad++;
                        $error("FAIL latency got=%0d expected=2", cyc - t);
                    end
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        held = got;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, sub));
            acc_q.push_back(cyc);
            sent++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            ta[i]   = W'($urandom());
            tb_v[i] = W'($urandom());
            ts[i]   = 1'($urandom_range(0, 1));
        end
    endtask

    // mode 0: out_ready=1, 1: out_ready=0, 2: random out_ready
    task automatic run(input int n, input int maxc, input int mode);
        for (int c = 0; c < maxc; c++) begin
            if (mode != 1 && sent >= n && exp_q.size() == 0) break;
            out_ready = (mode == 0) ? 1'b1 :
                        (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (sent < n) begin
                in_valid = 1'b1;
                a   = ta[sent];
                b   = tb_v[sent];
                sub = ts[sent];
            end else begin
                in_valid = 1'b0;
                a   = W'($urandom());
                b   = W'($urandom());
                sub = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        if (mode != 1) begin
            total++;
            assert (sent == n && exp_q.size() == 0) else begin
                bad++;
                $error("FAIL drain got sent=%0d q=%0d expected sent=%0d q=0",
                       sent, exp_q.size(), n);
            end
        end
    endtask

    task automatic dir(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic [W+3:0] e);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        cycle();
        in_valid = 1'b0;
        a = W'($urandom());
        b = W'($urandom());
        cycle();
        total++;
        assert ({out_valid, out, ovf, zero, neg} === {1'b1, e}) else begin
            bad++;
            $error("FAIL directed got=%b_%h expected=1_%h",
                   out_valid, {out, ovf, zero, neg}, e);
        end
        cycle();
    endtask

    initial begin
        #12;
        total++;
        assert (out_valid === 1'b0) else begin
            bad++; $error("FAIL rst_valid got=%b expected=0", out_valid);
        end
        total++;
        assert (in_ready === 1'b1) else begin
            bad++; $error("FAIL rst_ready got=%b expected=1", in_ready);
        end
        total++;
        assert ({out, ovf, zero, neg} === '0) else begin
            bad++; $error("FAIL rst_out got=%h expected=0", {out, ovf, zero, neg});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        lat_chk = 1'b1;
        dir(8'd5, 8'd3, 1'b1, {9'h102, 3'b000});
        dir(8'd3, 8'd5, 1'b1, {9'h0FE, 3'b001});
        dir(8'hA5, 8'hA5, 1'b1, {9'h100, 3'b010});
`ifdef ADDSUB_PIPE_SAT_EN
        dir(8'h7F, 8'h01, 1'b0, {9'h07F, 3'b101});
`else
        dir(8'h7F, 8'h01, 1'b0, {9'h080, 3'b101});
`endif
        fill(6);
        sent = 0;
        run(6, 40, 0);
        lat_chk = 1'b0;

        fill(4);
        sent = 0;
        run(4, 6, 1);
        total++;
        assert (sent == 2 && in_ready === 1'b0) else begin
            bad++;
            $error("FAIL backpressure got sent=%0d rdy=%b expected sent=2 rdy=0",
                   sent, in_ready);
        end
        run(4, 40, 0);

        fill(2);
        sent = 0;
        run(2, 2, 1);
        rst_n = 1'b0;
        #1;
        total++;
        assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
            bad++;
            $error("FAIL midrst got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
        exp_q.delete();
        acc_q.delete();
        prev_stall = 1'b0;
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        fill(1);
        sent = 0;
        lat_chk = 1'b1;
        run(1, 10, 0);
        lat_chk = 1'b0;

        fill(16);
        sent = 0;
        run(16, 300, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand width in bits (legal range 2..64).
- REQ-002 The block SHALL have parameter LO_W, default WIDTH/2, meaning the width of the low half of the carry chain that is computed in stage 1 (legal range 1..WIDTH-1).
- REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 in_valid  input  1  the operand beat is valid.
- REQ-006 in_ready  output  1  the block accepts the beat this cycle.
- REQ-007 a  input  WIDTH  minuend or first addend.
- REQ-008 b  input  WIDTH  subtrahend or second addend.
- REQ-009 sub  input  1  operation select: 1 = a-b, 0 = a+b.
- REQ-010 out_valid  output  1  the result beat is valid.
- REQ-011 out_ready  input  1  the downstream consumer accepts the result.
- REQ-012 out  output  WIDTH+1  result as {cout, sum}.
- REQ-013 ovf  output  1  signed two's-complement overflow.
- REQ-014 zero  output  1  the sum field of out is all zeros.
- REQ-015 neg  output  1  the MSB of the sum field of out.

Function
- REQ-016 The block SHALL compute sum and cout as a + (b XOR {WIDTH{sub}}) + sub; for sub=1, cout=1 SHALL mean no borrow (a >= b unsigned).
- REQ-017 ovf SHALL be 1 when the signs of a and the effective b (b XOR {WIDTH{sub}}) are equal and the sign of sum differs from them.
- REQ-018 Stage 1 SHALL register the low LO_W sum bits, the low carry-out, and the upper operand bits together with sub; stage 2 SHALL complete the upper chain and compute the flags.
- REQ-019 A beat is accepted when in_valid && in_ready; its result SHALL appear on out_valid exactly 2 cycles later if downstream does not stall.
- REQ-020 Throughput SHALL be one beat per cycle when out_ready is held at 1.
- REQ-021 in_ready SHALL equal !s1_valid || !s2_valid || out_ready; the stages shift only when the next stage is empty or is draining.
- REQ-022 While out_valid=1 && out_ready=0, out, ovf, zero and neg SHALL hold stable.
- REQ-023 When stalled, the pipeline SHALL hold at most 2 beats, and no beat SHALL be dropped or duplicated.
- REQ-024 Simultaneous accept at the input and drain at the output SHALL advance the pipeline in the same cycle.
- REQ-025 Results SHALL emerge in acceptance order.
- REQ-026 Operands SHALL be sampled only on acceptance; changes to a, b or sub while in_ready=0 SHALL have no effect.

Reset
- REQ-027 When rst_n=0, s1_valid, s2_valid and out_valid SHALL clear to 0 immediately, without waiting for a clock edge.
- REQ-028 During reset, out, ovf, zero and neg SHALL be 0, and in_ready SHALL be 1.
- REQ-029 A reset asserted mid-operation SHALL discard all in-flight beats, and no result for them SHALL appear after deassertion.
- REQ-030 The first accept SHALL be possible on the first rising clk edge after rst_n goes high.

Configuration
- REQ-031 With macro ADDSUB_PIPE_SAT_EN defined, when ovf=1 the sum field SHALL clamp to the signed limit: 0111..1 if the operand sign is 0, and 1000..0 if it is 1.
- REQ-032 With ADDSUB_PIPE_SAT_EN defined, cout, ovf and neg SHALL report the unclamped result, and zero SHALL reflect the clamped sum.
- REQ-033 Without ADDSUB_PIPE_SAT_EN, the sum SHALL wrap modulo 2^WIDTH and no clamp logic SHALL be present.

Verification (WIDTH=8, LO_W=4)
- REQ-034 sub=1, a=5, b=3, out_ready=1 -> two cycles later out=9'h102, ovf=0, zero=0, neg=0.
- REQ-035 sub=1, a=3, b=5 -> out=9'h0FE (borrow, cout=0), neg=1, ovf=0; sub=1, a=b=8'hA5 -> out=9'h100, zero=1.
- REQ-036 sub=0, a=8'h7F, b=8'h01 -> out=9'h080, ovf=1, neg=1; with ADDSUB_PIPE_SAT_EN -> sum=8'h7F, ovf=1, neg=1, zero=0.
- REQ-037 Backpressure: out_ready=0 with 4 back-to-back beats offered -> exactly 2 accepted, in_ready=0 from the 3rd cycle, outputs stable; releasing out_ready -> all 4 results delivered in order, none lost.
- REQ-038 Reset mid-operation: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately; after release, no stale result appears and the next beat has 2-cycle latency.
- REQ-039 Streaming: 16 random beats with out_ready toggling pseudo-randomly -> every result matches the reference model bit-exactly, in order.
